// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush controller with mult/div sequencer and stall-cycle counter
// Ports: clk, reset (sync, active-high); ID hazard inputs (id_rsAddr, id_rtAddr, id_rsRead, id_rtRead,
// id_branchTaken); EX inputs (ex_memRead, ex_writebackAddress, ex_mdStart, ex_mdIsDiv); mem_stallReq;
// outputs stall[5:0] (PC, IF, ID, EX, MEM, WB), flush, md_busy, md_done, stallCount.
module pipeline_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rsAddr,
  input  logic [4:0]  id_rtAddr,
  input  logic        id_rsRead,
  input  logic        id_rtRead,
  input  logic        id_branchTaken,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_writebackAddress,
  input  logic        ex_mdStart,
  input  logic        ex_mdIsDiv,
  input  logic        mem_stallReq,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stallCount
);
  typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;
  state_t state, state_nx;
  logic [31:0] cnt, cnt_nx, n;
  logic md_stall, load_use;
  assign n = ex_mdIsDiv ? 32'(DIV_CYCLES) : 32'(MUL_CYCLES);
  assign load_use = ex_memRead && ex_writebackAddress != 5'd0 &&
                    ((id_rsRead && id_rsAddr == ex_writebackAddress) ||
                     (id_rtRead && id_rtAddr == ex_writebackAddress));
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      stallCount <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      stallCount <= (stall != 6'd0 && stallCount != 32'hFFFF_FFFF) ? stallCount + 32'd1 : stallCount;
    end
  end
  // A start under a memory wait is deferred; once running, the count ignores memory waits.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (ex_mdStart && !mem_stallReq) begin
        cnt_nx   = n - 32'd1;
        state_nx = (n == 32'd1) ? MD_DONE : MD_RUN;
      end
      MD_RUN: begin
        cnt_nx   = cnt - 32'd1;
        state_nx = (cnt == 32'd1) ? MD_DONE : MD_RUN;
      end
      MD_DONE: state_nx = mem_stallReq ? MD_DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    md_stall = (state == IDLE && ex_mdStart) || state == MD_RUN;
    stall    = reset        ? 6'b000000 :
               mem_stallReq ? 6'b011111 :
               md_stall     ? 6'b001111 :
               load_use     ? 6'b000111 : 6'b000000;
    flush    = !reset && id_branchTaken && stall == 6'd0;
    md_busy  = !reset && state == MD_RUN;
    md_done  = !reset && state == MD_DONE;
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rsAddr, id_rtAddr, ex_writebackAddress;
  logic        id_rsRead, id_rtRead, id_branchTaken, ex_memRead;
  logic        ex_mdStart, ex_mdIsDiv, mem_stallReq;
  logic [5:0]  stall;
  logic        flush, md_busy, md_done;
  logic [31:0] stallCount;
  int checks = 0;
  int errors = 0;
  pipeline_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .id_rsAddr(id_rsAddr), .id_rtAddr(id_rtAddr),
    .id_rsRead(id_rsRead), .id_rtRead(id_rtRead),
    .id_branchTaken(id_branchTaken),
    .ex_memRead(ex_memRead), .ex_writebackAddress(ex_writebackAddress),
    .ex_mdStart(ex_mdStart), .ex_mdIsDiv(ex_mdIsDiv),
    .mem_stallReq(mem_stallReq),
    .stall(stall), .flush(flush), .md_busy(md_busy), .md_done(md_done),
    .stallCount(stallCount)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    id_rsAddr = 0; id_rtAddr = 0; ex_writebackAddress = 0;
    id_rsRead = 0; id_rtRead = 0; id_branchTaken = 0; ex_memRead = 0;
    ex_mdStart = 0; ex_mdIsDiv = 0; mem_stallReq = 0;
  endtask
  initial begin
    clear();
    reset = 1;
    ex_mdStart = 1; mem_stallReq = 1; id_branchTaken = 1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_busy", 32'(md_busy), 32'h0);
      chk("rst_done", 32'(md_done), 32'h0);
      chk("rst_count", stallCount, 32'h0);
      cyc();
    end
    reset = 0;
    @(negedge clk);
    chk("post_rst_prio", 32'(stall), 32'h1F);
    chk("post_rst_flush", 32'(flush), 32'h0);
    cyc();
    clear();
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'h0);
    chk("idle_busy", 32'(md_busy), 32'h0);
    cyc();
    ex_memRead = 1; ex_writebackAddress = 8; id_rsRead = 1; id_rsAddr = 8; id_branchTaken = 1;
    @(negedge clk);
    chk("lu_rs_stall", 32'(stall), 32'h07);
    chk("lu_branch_flush", 32'(flush), 32'h0);
    cyc();
    ex_writebackAddress = 0; id_rsAddr = 0;
    @(negedge clk);
    chk("lu_r0_stall", 32'(stall), 32'h0);
    chk("branch_flush", 32'(flush), 32'h1);
    cyc();
    id_branchTaken = 0; id_rsRead = 0; id_rtRead = 1; id_rtAddr = 9; ex_writebackAddress = 9;
    @(negedge clk);
    chk("lu_rt_stall", 32'(stall), 32'h07);
    cyc();
    id_rtRead = 0;
    @(negedge clk);
    chk("lu_noread_stall", 32'(stall), 32'h0);
    cyc();
    clear();
    ex_mdStart = 1; ex_mdIsDiv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mul_stall", 32'(stall), 32'h0F);
      chk("mul_busy", 32'(md_busy), (i > 0) ? 32'h1 : 32'h0);
      chk("mul_done_early", 32'(md_done), 32'h0);
      cyc();
    end
    ex_mdStart = 0;
    @(negedge clk);
    chk("mul_done", 32'(md_done), 32'h1);
    chk("mul_done_stall", 32'(stall), 32'h0);
    chk("mul_done_busy", 32'(md_busy), 32'h0);
    cyc();
    ex_mdStart = 1; ex_mdIsDiv = 1;
    @(negedge clk);
    chk("b2b_idle_done", 32'(md_done), 32'h0);
    chk("div_issue_stall", 32'(stall), 32'h0F);
    cyc();
    for (int i = 1; i < 32; i++) begin
      mem_stallReq = (i >= 10 && i < 13);
      @(negedge clk);
      chk("div_stall", 32'(stall), mem_stallReq ? 32'h1F : 32'h0F);
      chk("div_busy", 32'(md_busy), 32'h1);
      cyc();
    end
    ex_mdStart = 0; mem_stallReq = 1;
    @(negedge clk);
    chk("div_done", 32'(md_done), 32'h1);
    chk("div_done_mem_stall", 32'(stall), 32'h1F);
    cyc();
    @(negedge clk);
    chk("div_done_held", 32'(md_done), 32'h1);
    cyc();
    mem_stallReq = 0;
    @(negedge clk);
    chk("div_done_release", 32'(md_done), 32'h1);
    chk("div_release_stall", 32'(stall), 32'h0);
    cyc();
    @(negedge clk);
    chk("div_idle_done", 32'(md_done), 32'h0);
    chk("div_idle_busy", 32'(md_busy), 32'h0);
    ex_mdStart = 1; ex_mdIsDiv = 0;
    cyc();
    cyc();
    reset = 1;
    @(negedge clk);
    chk("midrst_busy", 32'(md_busy), 32'h0);
    chk("midrst_stall", 32'(stall), 32'h0);
    cyc();
    reset = 0; ex_mdStart = 0;
    @(negedge clk);
    chk("midrst_done", 32'(md_done), 32'h0);
    chk("midrst_idle_busy", 32'(md_busy), 32'h0);
    chk("midrst_count", stallCount, 32'h0);
    mem_stallReq = 1;
    for (int i = 0; i < 10; i++) cyc();
    mem_stallReq = 0;
    @(negedge clk);
    chk("count_10", stallCount, 32'd10);
    cyc();
    @(negedge clk);
    chk("count_hold", stallCount, 32'd10);
    force dut.stallCount = 32'hFFFF_FFFE;
    #1;
    release dut.stallCount;
    mem_stallReq = 1;
    cyc();
    chk("count_sat1", stallCount, 32'hFFFF_FFFF);
    cyc();
    cyc();
    chk("count_sat3", stallCount, 32'hFFFF_FFFF);
    mem_stallReq = 0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Collects hazard and wait requests from ID, EX and MEM and drives the 6-bit stall vector into PC, IF_ID, ID_EX, EX_MEM and MEM_WB, plus the IF/ID flush.
- Owns the multi-cycle mult/div sequencing FSM, so EX holds for exactly the unit latency.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MUL_CYCLES, 4, EX cycles consumed by a multiply, including the issue cycle; must be >= 1.
- DIV_CYCLES, 32, EX cycles consumed by a divide, including the issue cycle; must be >= 1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- id_rsAddr  input  5  ID source register rs.
- id_rtAddr  input  5  ID source register rt.
- id_rsRead  input  1  ID instruction reads rs.
- id_rtRead  input  1  ID instruction reads rt.
- id_branchTaken  input  1  ID resolved a taken branch or jump.
- ex_memRead  input  1  EX instruction is a load.
- ex_writebackAddress  input  5  EX destination register.
- ex_mdStart  input  1  EX holds a mult/div; held high while EX is stalled.
- ex_mdIsDiv  input  1  1 = divide, 0 = multiply; valid with ex_mdStart.
- mem_stallReq  input  1  data memory not ready.
- stall  output  6  bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- flush  output  1  bubble IF/ID.
- md_busy  output  1  mult/div sequence in progress.
- md_done  output  1  mult/div result valid this cycle.
- stallCount  output  32  cycles with stall != 0, saturating.

Behaviour:
- Stage register convention:
  - Register i bubbles when stall[i]=1 and stall[i+1]=0.
  - Register i holds when both are 1.
  - stall is always a contiguous low-order run of ones.
- Priority, combinational on current inputs and state:
  - mem_stallReq gives 6'b011111.
  - Else md_stall gives 6'b001111.
  - Else load_use gives 6'b000111.
  - Else 6'b000000.
- load_use = ex_memRead & (ex_writebackAddress != 0) & ((id_rsRead & id_rsAddr == ex_writebackAddress) | (id_rtRead & id_rtAddr == ex_writebackAddress)).
- md_stall = (state==IDLE & ex_mdStart) | state==MD_RUN.
- flush = id_branchTaken & (stall == 0). A stalled branch re-resolves on a later cycle.
- While reset is high, stall=0, flush=0, md_busy=0 and md_done=0.
- Registered reset values: state=IDLE, counter=0, stallCount=0.
- FSM states: IDLE, MD_RUN, MD_DONE.
  - IDLE:
    - Taken when ex_mdStart=1 and mem_stallReq=0.
    - Load counter with N-1, where N = ex_mdIsDiv ? DIV_CYCLES : MUL_CYCLES.
    - Go to MD_RUN, or directly to MD_DONE if N==1.
    - With mem_stallReq=1, stay in IDLE; the start is deferred.
  - MD_RUN:
    - md_busy=1.
    - The counter decrements every cycle, regardless of mem_stallReq.
    - When counter==1, go to MD_DONE.
  - MD_DONE:
    - md_done=1, md_busy=0, md_stall=0; EX advances this cycle.
    - If mem_stallReq=1, remain in MD_DONE with md_done held until it clears, then go to IDLE.
    - ex_mdStart is ignored in this state.
  - Total EX stall from an uncontended start is exactly N cycles (issue cycle plus N-1 MD_RUN cycles); release occurs in the MD_DONE cycle.
  - A back-to-back mult/div following MD_DONE is accepted in IDLE on the next cycle.
- stallCount increments on every clock with stall != 0 and saturates at 32'hFFFF_FFFF.
- Reset mid-sequence returns to IDLE immediately, with no md_done pulse.

Test Plan:
- Reset: assert reset with ex_mdStart=1 and mem_stallReq=1. Required: stall=0, flush=0, md_busy=0 and stallCount=0 throughout, and for the first cycle after release, stall follows priority.
- Load-use:
  - ex_memRead=1, ex_writebackAddress=8, id_rsRead=1, id_rsAddr=8: stall=6'b000111 for one cycle.
  - Same with ex_writebackAddress=0: stall=0.
- Multiply with MUL_CYCLES=4: pulse the sequence with ex_mdStart=1, ex_mdIsDiv=0. Required: stall=6'b001111 for exactly 4 cycles, md_busy high for 3, md_done high on the 5th cycle with stall=0.
- Divide overlapped by memory wait:
  - Divide starts; mem_stallReq is asserted for 3 cycles mid-run.
  - Required: stall=6'b011111 during the wait, MD_DONE still reached 32 cycles after start.
  - If mem_stallReq overlaps MD_DONE, md_done is held until it clears.
- Branch vs stall:
  - id_branchTaken=1 with no hazard: flush=1.
  - id_branchTaken=1 concurrent with load_use: flush=0, stall=6'b000111.
- Counter:
  - 10 stalled cycles: stallCount=10.
  - Force the counter to 32'hFFFF_FFFE and stall 3 cycles: stallCount=32'hFFFF_FFFF.
